// File: rtl/dram_wr_sched_pkg.sv
// Shared types and widths for the DRAM write scheduler and the conv/maxpool packers.
// Combinational content only: no latency and no backpressure.
package dram_wr_sched_pkg;

  localparam int DRAM_DATA_W = 64;
  localparam int DRAM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dram_wr_sched_if.sv
// Packer-to-scheduler write request channel; the word moves when valid and ready are both high.
// Wires only: no latency. The receiver throttles the sender by holding ready low.
interface dram_wr_sched_if
  import dram_wr_sched_pkg::*;
#(
  parameter int DATA_W = DRAM_DATA_W
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dram_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, combinational from elig (0 cycles).
// Backpressure: an ineligible input is never granted; the pointer only moves on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 means requester 1 won most recently, so requester 0 wins the next tie.
  logic last;

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/dram_wr_sched.sv
// Round-robin scheduler for two packers on one DRAM write port, with address generation and a done pulse.
// Latency: the write is registered 1 cycle after acceptance. Backpressure: ready is the arbiter grant.
module dram_wr_sched
  import dram_wr_sched_pkg::*;
#(
  parameter int DATA_W = DRAM_DATA_W,
  parameter int ADDR_W = DRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] len0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [ADDR_W-1:0] len1,
  dram_wr_sched_if.slave    req0,
  dram_wr_sched_if.slave    req1,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base0_q, len0_q, base1_q, len1_q;
  logic [ADDR_W-1:0] cnt0, cnt1;
  logic [ADDR_W-1:0] cnt0_nxt, cnt1_nxt;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              take;
  logic              in_idle;
  logic              in_run;
  logic              err_set;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RUN exits on the post-increment counts, so a final grant and the exit share a cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if ((cnt0_nxt == len0_q) && (cnt1_nxt == len1_q)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_idle = (state == IDLE);
    in_run  = (state == RUN);
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == DONE);
  end

  assign elig[0] = in_run && req0.valid && (cnt0 < len0_q);
  assign elig[1] = in_run && req1.valid && (cnt1 < len1_q);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig   (elig),
    .update (take),
    .grant  (grant)
  );

  assign take       = |grant;
  assign req0.ready = grant[0];
  assign req1.ready = grant[1];
  assign cnt0_nxt   = cnt0 + ADDR_W'(grant[0]);
  assign cnt1_nxt   = cnt1 + ADDR_W'(grant[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base0_q <= '0;
      len0_q  <= '0;
      base1_q <= '0;
      len1_q  <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
    end else if (in_idle && start) begin
      base0_q <= base0;
      len0_q  <= len0;
      base1_q <= base1;
      len1_q  <= len1;
      cnt0    <= '0;
      cnt1    <= '0;
    end else if (in_run) begin
      cnt0    <= cnt0_nxt;
      cnt1    <= cnt1_nxt;
    end
  end

  // Address and data hold their last values while no write is issued; the sum wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
    end else begin
      dram_we <= take;
      if (grant[0]) begin
        dram_addr  <= base0_q + cnt0;
        dram_wdata <= req0.data;
      end else if (grant[1]) begin
        dram_addr  <= base1_q + cnt1;
        dram_wdata <= req1.data;
      end
    end
  end

  assign err_set = (in_run && ((req0.valid && (cnt0 == len0_q)) ||
                               (req1.valid && (cnt1 == len1_q)))) ||
                   (in_idle && (req0.valid || req1.valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (in_idle && start) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_wr_sched.sv
// Directed bench for dram_wr_sched: expected writes are queued up front and a negedge monitor
// checks every DRAM write against the queue and against its acceptance cycle.
module tb_dram_wr_sched;
  import dram_wr_sched_pkg::*;

  localparam int AW = DRAM_ADDR_W;
  localparam int DW = DRAM_DATA_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start;
  logic [AW-1:0] base0, len0, base1, len1;
  logic          dram_we;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic          busy, done, err;

  dram_wr_sched_if #(.DATA_W(DW)) req0_if ();
  dram_wr_sched_if #(.DATA_W(DW)) req1_if ();

  dram_wr_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base0      (base0),
    .len0       (len0),
    .base1      (base1),
    .len1       (len1),
    .req0       (req0_if),
    .req1       (req1_if),
    .dram_we    (dram_we),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int  tests    = 0;
  int  fails    = 0;
  int  cyc      = 0;
  int  last_acc = -1;
  wr_t exp_q[$];
  int  acc_q[$];
  wr_t mon_e;
  int  mon_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor: pops one expected write per dram_we and checks the 1-cycle latency.
  always @(negedge clk) begin
    if (rst) begin
      chk("one_grant_per_cycle", 64'(req0_if.ready && req1_if.ready), 64'd0);
      if (dram_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, expected none", dram_addr, dram_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(dram_addr), 64'(mon_e.addr));
          chk("wr_data", dram_wdata, mon_e.data);
        end
        if (acc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_latency: got write with no prior acceptance, expected acceptance 1 cycle earlier");
        end else begin
          mon_a = acc_q.pop_front();
          chk("wr_latency", 64'(cyc - mon_a), 64'd1);
        end
      end
      if ((req0_if.valid && req0_if.ready) || (req1_if.valid && req1_if.ready)) begin
        acc_q.push_back(cyc);
        last_acc = cyc;
      end
    end
  end

  // Called at #1 after a posedge in IDLE; returns the cycle in which start was high.
  task automatic launch(input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                        input logic [AW-1:0] b1, input logic [AW-1:0] l1, output int sc);
    base0 = b0;
    len0  = l0;
    base1 = b1;
    len1  = l1;
    start = 1'b1;
    sc    = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input int sel, input int n, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] w;
    logic          acc;
    int            k;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : d3;
      if (sel == 0) begin
        req0_if.valid = 1'b1;
        req0_if.data  = w;
      end else begin
        req1_if.valid = 1'b1;
        req1_if.data  = w;
      end
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 50) begin
        @(negedge clk);
        acc = (sel == 0) ? req0_if.ready : req1_if.ready;
        @(posedge clk);
        #1;
        k++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL send%0d_timeout: got no ready for word %0d in 50 cycles, expected acceptance", sel, i);
      end
    end
    if (sel == 0) req0_if.valid = 1'b0;
    else          req1_if.valid = 1'b0;
  endtask

  task automatic finish_job(input string nm, output int dc);
    int k;
    dc = -1;
    k  = 0;
    while (dc < 0 && k < 40) begin
      @(negedge clk);
      if (done) dc = cyc;
      k++;
    end
    if (dc < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout: got no done in 40 cycles, expected a done pulse", nm);
    end else begin
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({nm, "_done_single"}, 64'(done), 64'd0);
      chk({nm, "_busy_after"}, 64'(busy), 64'd0);
      chk({nm, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sc;
    int dc;
    start = 1'b0;
    base0 = '0; len0 = '0; base1 = '0; len1 = '0;
    req0_if.valid = 1'b0; req0_if.data = '0;
    req1_if.valid = 1'b0; req1_if.data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 64'(dram_we), 64'd0);
    chk("rst_addr", 64'(dram_addr), 64'd0);
    chk("rst_wdata", dram_wdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Contention straight after reset: requester 0 wins first, then strict alternation.
    exp_wr(10'h000, 64'hA0A0_0000_0000_0000);
    exp_wr(10'h200, 64'hB0B0_0000_0000_0000);
    exp_wr(10'h001, 64'hA1A1_0000_0000_0001);
    exp_wr(10'h201, 64'hB1B1_0000_0000_0001);
    launch(10'h000, 10'd2, 10'h200, 10'd2, sc);
    fork
      send(0, 2, 64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001, '0, '0);
      send(1, 2, 64'hB0B0_0000_0000_0000, 64'hB1B1_0000_0000_0001, '0, '0);
    join
    finish_job("cont", dc);

    // Single requester: three back-to-back words, done two cycles after the last acceptance.
    exp_wr(10'h100, 64'hD000_0000_0000_0000);
    exp_wr(10'h101, 64'hD111_1111_1111_1111);
    exp_wr(10'h102, 64'hD222_2222_2222_2222);
    launch(10'h100, 10'd3, 10'h000, 10'd0, sc);
    send(0, 3, 64'hD000_0000_0000_0000, 64'hD111_1111_1111_1111, 64'hD222_2222_2222_2222, '0);
    finish_job("single", dc);
    chk("single_done_latency", 64'(dc - last_acc), 64'd2);
    chk("single_err", 64'(err), 64'd0);

    // Over-run by requester 0, plus a start pulse in RUN that must not reload base1 or the counters.
    exp_wr(10'h040, 64'hE0E0_E0E0_E0E0_E0E0);
    exp_wr(10'h050, 64'hF0F0_F0F0_F0F0_F0F0);
    launch(10'h040, 10'd1, 10'h050, 10'd1, sc);
    req0_if.valid = 1'b1;
    req0_if.data  = 64'hE0E0_E0E0_E0E0_E0E0;
    @(negedge clk);
    chk("ovr_ready_first", 64'(req0_if.ready), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b1;
    base1 = 10'h1F0;
    @(negedge clk);
    chk("ovr_ready_second", 64'(req0_if.ready), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ovr_ready_third", 64'(req0_if.ready), 64'd0);
    chk("ovr_err_set", 64'(err), 64'd1);
    chk("ovr_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 req0_if.valid = 1'b0;
    send(1, 1, 64'hF0F0_F0F0_F0F0_F0F0, '0, '0, '0);
    finish_job("ovr", dc);
    chk("ovr_err_sticky", 64'(err), 64'd1);

    // Address wrap on requester 1; the accepted start clears the sticky error.
    exp_wr(10'h3FE, 64'h0000_0000_0000_3FE0);
    exp_wr(10'h3FF, 64'h0000_0000_0000_3FF1);
    exp_wr(10'h000, 64'h0000_0000_0000_0002);
    exp_wr(10'h001, 64'h0000_0000_0000_0013);
    launch(10'h000, 10'd0, 10'h3FE, 10'd4, sc);
    @(negedge clk);
    chk("wrap_err_cleared", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    send(1, 4, 64'h0000_0000_0000_3FE0, 64'h0000_0000_0000_3FF1,
         64'h0000_0000_0000_0002, 64'h0000_0000_0000_0013);
    finish_job("wrap", dc);
    chk("wrap_err", 64'(err), 64'd0);

    // Zero-length job: no writes at all, done three cycles after start.
    launch(10'h123, 10'd0, 10'h321, 10'd0, sc);
    @(negedge clk);
    chk("zero_busy_run", 64'(busy), 64'd1);
    chk("zero_no_ready", 64'(req0_if.ready || req1_if.ready), 64'd0);
    finish_job("zero", dc);
    chk("zero_done_latency", 64'(dc - sc), 64'd3);

    // Reset mid-job after one of four writes: outputs clear at once, next job restarts from base0.
    exp_wr(10'h080, 64'h6060_0000_0000_0000);
    launch(10'h080, 10'd4, 10'h000, 10'd0, sc);
    req0_if.valid = 1'b1;
    req0_if.data  = 64'h6060_0000_0000_0000;
    @(negedge clk);
    @(posedge clk);
    #1 req0_if.data = 64'h6161_0000_0000_0001;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_we", 64'(dram_we), 64'd0);
    chk("mrst_addr", 64'(dram_addr), 64'd0);
    chk("mrst_wdata", dram_wdata, 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(req0_if.ready), 64'd0);
    req0_if.valid = 1'b0;
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle", 64'(busy), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    exp_wr(10'h080, 64'h7070_0000_0000_0000);
    exp_wr(10'h081, 64'h7171_0000_0000_0001);
    launch(10'h080, 10'd2, 10'h000, 10'd0, sc);
    send(0, 2, 64'h7070_0000_0000_0000, 64'h7171_0000_0000_0001, '0, '0);
    finish_job("mrst_restart", dc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
